// File: rtl/adc_proc_pkg.sv
// Shared types and helpers for the multi-channel ADC averaging datapath.
package adc_proc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    ACC   = 3'd2,
    SCALE = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Gain is unsigned fixed point with this many fraction bits
  localparam int unsigned GAIN_FRAC = 8;

  // Clamp an unsigned value to the largest number representable in width bits
  function automatic logic [63:0] sat_u(input logic [63:0] val, input int width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/adc_sample_ram.sv
// Sample history store: one 2^POWER-deep window per channel, 1R1W, synchronous read.
module adc_sample_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset: stale contents are masked by the per-channel fill count
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_multich_averager.sv
// Multi-channel ADC moving-average stage with Q8.8 gain, saturation and a
// per-channel result bank.
module adc_multich_averager
  import adc_proc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int POWER  = 8,
  parameter int GAIN_W = 16,
  // Derived channel tag width; leave at its default
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  input  logic [DATA_W-1:0]        data,
  input  logic [CH_W-1:0]          ch,
  input  logic [GAIN_W-1:0]        gain,
  input  logic                     clear,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  output logic                     out_primed,
  output logic [N_CH*DATA_W-1:0]   out_bank,
  output logic                     overrun,
  output logic                     bad_ch
);

  localparam int SUM_W  = DATA_W + POWER;
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int ADDR_W = CH_W + POWER;
  localparam logic [POWER:0]  FULL   = {1'b1, {POWER{1'b0}}};
  localparam logic [CH_W:0]   N_CH_L = (CH_W+1)'(N_CH);

  state_t state_q, state_d;

  logic                ready_q;
  logic                pulse_s;
  logic                ch_ok_s;
  logic                accept_s;
  logic                rd_en_s;
  logic                acc_en_s;
  logic                scale_en_s;

  logic [DATA_W-1:0]   smp_q, smp_d;
  logic [CH_W-1:0]     ch_q, ch_d;

  logic [SUM_W-1:0]    sum_q  [N_CH];
  logic [SUM_W-1:0]    sum_d  [N_CH];
  logic [POWER:0]      cnt_q  [N_CH];
  logic [POWER:0]      cnt_d  [N_CH];
  logic [POWER-1:0]    wptr_q [N_CH];
  logic [POWER-1:0]    wptr_d [N_CH];

  logic [ADDR_W-1:0]   ram_addr_s;
  logic                ram_we_s;
  logic [DATA_W-1:0]   ram_q_s;
  logic [DATA_W-1:0]   old_s;

  logic [DATA_W-1:0]   avg_s;
  logic [PROD_W-1:0]   prod_s;
  logic [DATA_W-1:0]   res_s;

  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_primed_q, out_primed_d;
  logic [N_CH*DATA_W-1:0]  out_bank_q, out_bank_d;
  logic                    overrun_q, overrun_d;
  logic                    bad_ch_q, bad_ch_d;

  assign pulse_s  = ready & ~ready_q;
  assign ch_ok_s  = ({1'b0, ch} < N_CH_L);
  assign accept_s = pulse_s & (state_q == IDLE) & ch_ok_s & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = accept_s ? RD : IDLE;
        RD:      state_d = ACC;
        ACC:     state_d = SCALE;
        SCALE:   state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en_s    = 1'b0;
    acc_en_s   = 1'b0;
    scale_en_s = 1'b0;
    case (state_q)
      RD:      rd_en_s    = 1'b1;
      ACC:     acc_en_s   = 1'b1;
      SCALE:   scale_en_s = 1'b1;
      default: rd_en_s    = 1'b0;
    endcase
  end

  assign ram_addr_s = {ch_q, wptr_q[ch_q]};
  assign ram_we_s   = acc_en_s & ~clear;

  adc_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (N_CH << POWER)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_addr_s),
    .wdata (smp_q),
    .re    (rd_en_s),
    .raddr (ram_addr_s),
    .rdata (ram_q_s)
  );

  // Until the window has filled, the slot being overwritten holds no real sample
  assign old_s = (cnt_q[ch_q] == FULL) ? ram_q_s : '0;

  always_comb begin
    smp_d = accept_s ? data : smp_q;
    ch_d  = accept_s ? ch   : ch_q;
  end

  always_comb begin
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    if (clear) begin
      for (int i = 0; i < N_CH; i++) begin
        sum_d[i]  = '0;
        cnt_d[i]  = '0;
        wptr_d[i] = '0;
      end
    end else if (acc_en_s) begin
      sum_d[ch_q]  = sum_q[ch_q] + SUM_W'(smp_q) - SUM_W'(old_s);
      wptr_d[ch_q] = wptr_q[ch_q] + POWER'(1);
      cnt_d[ch_q]  = (cnt_q[ch_q] == FULL) ? FULL : cnt_q[ch_q] + (POWER+1)'(1);
    end else begin
      sum_d  = sum_q;
    end
  end

  assign avg_s  = sum_q[ch_q][SUM_W-1:POWER];
  assign prod_s = PROD_W'(avg_s) * PROD_W'(gain);
  assign res_s  = DATA_W'(sat_u(64'(prod_s >> GAIN_FRAC), DATA_W));

  // Result is captured at the end of SCALE so it is visible throughout OUT
  always_comb begin
    out_valid_d  = scale_en_s & ~clear;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_primed_d = out_primed_q;
    out_bank_d   = out_bank_q;
    if (out_valid_d) begin
      out_data_d   = res_s;
      out_ch_d     = ch_q;
      out_primed_d = (cnt_q[ch_q] == FULL);
      out_bank_d[int'(ch_q)*DATA_W +: DATA_W] = res_s;
    end else begin
      out_bank_d   = out_bank_q;
    end
    if (clear) begin
      overrun_d = 1'b0;
      bad_ch_d  = 1'b0;
    end else begin
      overrun_d = overrun_q | (pulse_s & (state_q != IDLE));
      bad_ch_d  = bad_ch_q  | (pulse_s & (state_q == IDLE) & ~ch_ok_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b0;
      smp_q        <= '0;
      ch_q         <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      out_primed_q <= 1'b0;
      out_bank_q   <= '0;
      overrun_q    <= 1'b0;
      bad_ch_q     <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        sum_q[i]  <= '0;
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
      end
    end else begin
      ready_q      <= ready;
      smp_q        <= smp_d;
      ch_q         <= ch_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      out_primed_q <= out_primed_d;
      out_bank_q   <= out_bank_d;
      overrun_q    <= overrun_d;
      bad_ch_q     <= bad_ch_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign out_primed = out_primed_q;
  assign out_bank   = out_bank_q;
  assign overrun    = overrun_q;
  assign bad_ch     = bad_ch_q;

endmodule

// File: tb/tb_adc_multich_averager.sv
// Scoreboard bench for adc_multich_averager (2 channels, 4-sample window).
module tb_adc_multich_averager;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] data;
  logic        ch;
  logic [15:0] gain;
  logic        clear;
  logic [15:0] out_data;
  logic        out_ch;
  logic        out_valid;
  logic        out_primed;
  logic [31:0] out_bank;
  logic        overrun;
  logic        bad_ch;

  // With two channels the tag is one bit, so an out-of-range tag needs a
  // three-channel instance with its own ready line.
  logic        ready3;
  logic [1:0]  ch3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_primed3;
  logic [47:0] out_bank3;
  logic        overrun3;
  logic        bad_ch3;

  adc_multich_averager #(.N_CH(2), .DATA_W(16), .POWER(2), .GAIN_W(16)) u_dut (
    .clk(clk), .reset(reset), .ready(ready), .data(data), .ch(ch), .gain(gain),
    .clear(clear), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_primed(out_primed), .out_bank(out_bank), .overrun(overrun), .bad_ch(bad_ch)
  );

  adc_multich_averager #(.N_CH(3), .DATA_W(16), .POWER(2), .GAIN_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .ready(ready3), .data(data), .ch(ch3), .gain(gain),
    .clear(clear), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_primed(out_primed3), .out_bank(out_bank3), .overrun(overrun3), .bad_ch(bad_ch3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        p;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned hist0[$];
  int unsigned hist1[$];
  logic [15:0] last_d;
  int          cyc = 0;
  int          n_valid3 = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    hist0.delete();
    hist1.delete();
  endtask

  task automatic model_push(input logic [15:0] d, input logic c, input int at);
    longint unsigned s;
    longint unsigned r;
    exp_t e;
    s = 0;
    if (c == 1'b0) begin
      hist0.push_back(d);
      if (hist0.size() > 4) void'(hist0.pop_front());
      foreach (hist0[i]) s += hist0[i];
      e.p = (hist0.size() == 4);
    end else begin
      hist1.push_back(d);
      if (hist1.size() > 4) void'(hist1.pop_front());
      foreach (hist1[i]) s += hist1[i];
      e.p = (hist1.size() == 4);
    end
    r = ((s / 4) * gain) / 256;
    if (r > 64'd65535) r = 64'd65535;
    e.d = r[15:0];
    e.c = c;
    e.cyc = at;
    last_d = e.d;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input logic c);
    @(negedge clk);
    ready = 1'b1;
    data = d;
    ch = c;
    model_push(d, c, cyc);
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.d));
        check("out_ch", 64'(out_ch), 64'(mon_e.c));
        check("out_primed", 64'(out_primed), 64'(mon_e.p));
        check("latency", 64'(cyc - mon_e.cyc), 64'd4);
      end
    end
    if (out_valid3) n_valid3++;
  end

  initial begin
    reset = 1'b1; ready = 1'b0; data = 16'd0; ch = 1'b0;
    gain = 16'h0100; clear = 1'b0; ready3 = 1'b0; ch3 = 2'd0;
    last_d = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_primed", 64'(out_primed), 64'd0);
    check("rst_out_bank", 64'(out_bank), 64'd0);
    check("rst_flags", 64'({overrun, bad_ch}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Warm-up, then window wrap
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    send(16'd400, 1'b0);
    check("t1_last", 64'(out_data), 64'd250);
    check("t1_primed", 64'(out_primed), 64'd1);
    send(16'd800, 1'b0);
    check("t2_wrap", 64'(out_data), 64'd425);

    // Interleaved channels from a clean start
    @(negedge clk); clear = 1'b1; model_clear();
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(16'd1000, 1'b0);
      send(16'd40, 1'b1);
    end
    check("t3_bank", 64'(out_bank), {32'd0, 16'd40, 16'd1000});

    // Gain and saturation
    for (int i = 0; i < 4; i++) send(16'hF000, 1'b0);
    gain = 16'h0200;
    send(16'hF000, 1'b0);
    check("t4_sat", 64'(out_data), 64'hFFFF);
    gain = 16'h0080;
    send(16'hF000, 1'b0);
    check("t4_half", 64'(out_data), 64'h7800);
    gain = 16'h0100;

    // Overrun: second edge two cycles after the first is dropped
    @(negedge clk); ready = 1'b1; data = 16'd500; ch = 1'b0; model_push(16'd500, 1'b0, cyc);
    @(negedge clk); ready = 1'b0;
    @(negedge clk); ready = 1'b1; data = 16'd999;
    @(negedge clk); ready = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_overrun", 64'(overrun), 64'd1);
    check("t5_no_bad_ch", 64'(bad_ch), 64'd0);

    @(negedge clk); ready3 = 1'b1; ch3 = 2'd3;
    @(negedge clk); ready3 = 1'b0; ch3 = 2'd0;
    repeat (6) @(negedge clk);
    check("t5_bad_ch", 64'(bad_ch3), 64'd1);
    check("t5_bad_no_valid", 64'(n_valid3), 64'd0);

    // Clear while the sample is in ACC
    @(negedge clk); ready = 1'b1; data = 16'd123; ch = 1'b0;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); clear = 1'b1; model_clear();
    @(negedge clk); clear = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_overrun_clr", 64'(overrun), 64'd0);
    check("t6_hold", 64'(out_data), 64'(last_d));
    send(16'd400, 1'b0);
    check("t6_after_clear", 64'(out_data), 64'd100);
    check("t6_primed", 64'(out_primed), 64'd0);

    // Asynchronous reset during SCALE
    @(negedge clk); ready = 1'b1; data = 16'd800; ch = 1'b0;
    @(negedge clk); ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_data", 64'(out_data), 64'd0);
    check("rst_mid_bank", 64'(out_bank), 64'd0);
    check("rst_mid_valid", 64'({out_valid, out_primed}), 64'd0);
    model_clear();
    @(negedge clk); reset = 1'b0;
    send(16'd200, 1'b0);
    check("post_rst", 64'(out_data), 64'd50);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
